// File: rtl/packed_chan_arb_fifo_if.sv
// Handshake bundle for packed_chan_arb_fifo: NCH packed upstream channels
// and one downstream FIFO port with its occupancy.
interface packed_chan_arb_fifo_if #(
  parameter int NCH   = 3,
  parameter int W     = 8,
  parameter int DEPTH = 4
) ();
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]          in_vld;
  logic [NCH-1:0]          in_rdy;
  logic [0:NCH-1][W-1:0]   in_data;
  logic                    out_vld;
  logic                    out_rdy;
  logic [W-1:0]            out_data;
  logic [CW-1:0]           out_ch;
  logic [CNTW-1:0]         count;

  // Upstream producers plus downstream consumer.
  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_ch, count
  );

  // The arbitrating FIFO itself.
  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_ch, count
  );
endinterface

// File: rtl/packed_chan_arb_fifo.sv
// Round-robin arbiter over NCH valid/ready channels feeding an in-order FIFO
// that tags each entry with its source channel.
module packed_chan_arb_fifo #(
  parameter int NCH   = 3,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  packed_chan_arb_fifo_if.slave bus
);
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   rr;
  logic [CW-1:0]   grant_ch;
  logic [CW-1:0]   idx;
  logic [NCH-1:0]  grant;
  logic            push;
  logic            pop;
  logic            full;

  function automatic int wrap_ch(input int c);
    return (c >= NCH) ? c - NCH : c;
  endfunction

  assign full = (cnt == CNTW'(DEPTH));

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant    = '0;
    grant_ch = '0;
    idx      = '0;
    push     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'(wrap_ch(int'(rr) + i));
      if (!full && !push && bus.in_vld[idx]) begin
        grant[idx] = 1'b1;
        grant_ch   = idx;
        push       = 1'b1;
      end
    end
  end

  assign pop        = bus.out_vld & bus.out_rdy;
  assign head       = mem[rd_ptr];
  assign bus.in_rdy = grant;
  assign bus.out_vld  = (cnt != '0);
  assign bus.out_data = bus.out_vld ? head.data : '0;
  assign bus.out_ch   = bus.out_vld ? head.ch   : '0;
  assign bus.count    = cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr     <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage has no reset; a cleared count makes stale words unreachable,
  // and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= '{ch: grant_ch, data: bus.in_data[grant_ch]};
  end
endmodule

// File: tb/tb_packed_chan_arb_fifo.sv
// Randomized scoreboard bench for packed_chan_arb_fifo with directed
// scenarios for arbitration order, full/empty boundaries and mid-run reset.
module tb_packed_chan_arb_fifo;
  localparam int NCH   = 3;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  typedef struct {
    int ch;
    int data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ent_t mq[$];     // reference FIFO contents
  ent_t exp_q[$];  // scoreboard of expected output order
  int   rr_m = 0;

  packed_chan_arb_fifo_if #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) bus ();

  packed_chan_arb_fifo #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid channel at or after rr_m, wrapping; -1 when full or none valid.
  function automatic int model_grant(input logic [NCH-1:0] v);
    if (mq.size() >= DEPTH) return -1;
    for (int i = 0; i < NCH; i++)
      if (v[(rr_m + i) % NCH]) return (rr_m + i) % NCH;
    return -1;
  endfunction

  task automatic cycle(input logic [NCH-1:0] v, input logic [0:NCH-1][W-1:0] d,
                       input logic ordy, input logic rstn);
    int g;
    logic [NCH-1:0] exp_rdy;
    bit do_pop;
    @(negedge clk);
    bus.in_vld  = v;
    bus.in_data = d;
    bus.out_rdy = ordy;
    rst_n       = rstn;
    #1;
    g = model_grant(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
    check("count", 32'(bus.count), mq.size());
    check("out_vld", 32'(bus.out_vld), 32'(mq.size() != 0));
    do_pop = rstn && ordy && (mq.size() != 0);
    if (rstn && g >= 0) exp_q.push_back('{ch: g, data: int'(d[g])});
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      exp_q.delete();
      rr_m = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{ch: g, data: int'(d[g])});
        rr_m = (g + 1) % NCH;
      end
    end
  endtask

  // Monitor: compares the presented head with the scoreboard, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && rst_n) begin
        if (bus.out_vld === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: out_vld high with out_data 0x%0h but nothing expected", bus.out_data);
          end else begin
            check("out_data", 32'(bus.out_data), exp_q[0].data);
            check("out_ch", 32'(bus.out_ch), exp_q[0].ch);
            if (bus.out_rdy === 1'b1) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_data", 32'(bus.out_data), 0);
          check("idle_ch", 32'(bus.out_ch), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [0:NCH-1][W-1:0] d;
    logic [NCH-1:0] v;
    bus.in_vld  = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    // Post-reset state and channel-order grants with downstream stalled.
    d = {8'hA0, 8'hB1, 8'hC2};
    cycle('0, d, 1'b0, 1'b1);
    repeat (3) cycle(3'b111, d, 1'b0, 1'b1);
    // Fill to DEPTH, then stall with all channels requesting.
    cycle(3'b111, d, 1'b0, 1'b1);
    repeat (2) cycle(3'b111, d, 1'b0, 1'b1);
    // Full: first edge pops only, next edge pushes ch1 and pops.
    d = {8'h11, 8'h22, 8'h33};
    repeat (2) cycle(3'b010, d, 1'b1, 1'b1);
    // Mid-run reset with count=3, then rr restarts at ch0 so ch1 wins.
    cycle('0, d, 1'b0, 1'b0);
    cycle(3'b110, d, 1'b0, 1'b1);
    // Drain, then a single ch2 entry through an empty FIFO.
    repeat (2) cycle('0, d, 1'b1, 1'b1);
    d = {8'h00, 8'h00, 8'h55};
    cycle(3'b100, d, 1'b0, 1'b1);
    cycle('0, d, 1'b1, 1'b1);
    cycle('0, d, 1'b1, 1'b1);

    // Randomized traffic with pointer wrap, toggling out_rdy and rare resets.
    for (int n = 0; n < 600; n++) begin
      v = NCH'($urandom);
      for (int k = 0; k < NCH; k++) d[k] = W'($urandom);
      cycle(v, d, 1'($urandom_range(0, 2) != 0 ? 1 : 0) ^ (n[4] & n[0]),
            ($urandom_range(0, 99) != 0));
    end

    // Drain and confirm every expected entry came out.
    repeat (DEPTH + 2) cycle('0, d, 1'b1, 1'b1);
    check("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/packed_chan_arb_fifo.md
PACKED_CHAN_ARB_FIFO -- requirements
Module: packed_chan_arb_fifo

Interface
REQ-001 The block SHALL have parameter NCH, default 3, giving the number of input channels (2..16).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per channel.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the FIFO depth in entries (power of 2, >=2).
REQ-004 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have in_vld, input, NCH, per-channel valid.
REQ-007 The block SHALL have in_rdy, output, NCH, per-channel ready; one-hot or zero.
REQ-008 The block SHALL have in_data, input, 2D packed [0:NCH-1][W-1:0], with channel k at index k.
REQ-009 The block SHALL have out_vld, output, 1, FIFO head valid.
REQ-010 The block SHALL have out_rdy, input, 1, downstream ready.
REQ-011 The block SHALL have out_data, output, W, FIFO head data.
REQ-012 The block SHALL have out_ch, output, max(1,$clog2(NCH)), source channel of the head entry.
REQ-013 The block SHALL have count, output, $clog2(DEPTH)+1, number of stored entries.

Function
REQ-014 The block SHALL push a channel's entry when in_vld[k] and in_rdy[k] are both high at a rising edge, and SHALL pop the head when out_vld and out_rdy are both high.
REQ-015 The block SHALL accept at most one push per cycle; in_rdy SHALL be all-zero when count==DEPTH, with no bypass on a same-cycle pop.
REQ-016 When count<DEPTH, in_rdy SHALL be combinational and one-hot on the first asserted in_vld found by searching upward from the round-robin pointer rr, wrapping from NCH-1 to 0.
REQ-017 After a push from channel k, rr SHALL become (k+1) mod NCH; with no push, rr SHALL hold.
REQ-018 A pushed entry SHALL store {k, in_data[k]}; in_data of non-granted channels SHALL be ignored.
REQ-019 out_vld SHALL equal (count!=0); out_data and out_ch SHALL show the head entry when out_vld is high and SHALL be zero otherwise.
REQ-020 Latency SHALL be 1 cycle: an entry pushed into an empty FIFO at edge N SHALL have out_vld high after edge N.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and SHALL preserve order.
REQ-023 A pop at count==0 SHALL be impossible, because out_vld is low.
REQ-024 The FIFO SHALL be strictly in order, with no reordering by channel.
REQ-025 An upstream channel SHALL hold in_data[k] stable while in_vld[k] is high and in_rdy[k] is low; the block SHALL not check this.

Reset
REQ-026 While rst_n is low at a rising edge, count, the read and write pointers, and rr SHALL be cleared to 0.
REQ-027 After reset, outputs SHALL be out_vld=0, out_data=0, out_ch=0, count=0, and in_rdy SHALL be purely combinational from in_vld (one-hot from channel 0 search).
REQ-028 Reset asserted mid-operation SHALL discard all stored entries in the same edge; storage contents are not cleared and are unobservable.
REQ-029 The block SHALL ignore any push or pop qualified in a reset cycle.

Verification (NCH=3, W=8, DEPTH=4)
REQ-030 Directed test: after reset, in_vld=3'b111 with data A0/B1/C2 and out_rdy=0 for 3 cycles -> grants ch0, ch1, ch2 in order; count=3; rr=0.
REQ-031 Directed test: fill with 4 entries while out_rdy=0 -> count=4, in_rdy=0 while in_vld!=0; out_data=first entry and holds.
REQ-032 Directed test: with count=4, set out_rdy=1 and in_vld[1]=1 -> the first edge pops only (count=3); the next edge pushes ch1 and pops (count=3).
REQ-033 Directed test: push 0x55 from ch2 into an empty FIFO -> out_vld=1, out_data=0x55, out_ch=2 the next cycle; out_rdy=1 -> out_vld=0, out_data=0.
REQ-034 Directed test: stream 9 entries through with pointer wrap, mixed channels, out_rdy toggling -> output order equals push order and count never exceeds 4.
REQ-035 Directed test: rst_n=0 for one edge with count=3 -> count=0, out_vld=0, and a subsequent in_vld=3'b110 grants ch1 first.
